// File: rtl/game_referee.sv
// Round/match referee for a two-player fighting game: times each round, detects KO
// and timeouts, keeps the round and win counters, and decides the match.
module game_referee #(
    parameter int unsigned ROUND_TICKS   = 60,
    parameter int unsigned HOLD_TICKS    = 4,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_ROUNDS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] left_health,
    input  logic [2:0] right_health,
    output logic       round_active,
    output logic       round_restart,
    output logic [7:0] time_left,
    output logic [1:0] round_num,
    output logic [1:0] left_wins,
    output logic [1:0] right_wins,
    output logic       result_valid,
    output logic [1:0] round_result,
    output logic       match_over,
    output logic [1:0] match_winner
);
    localparam logic [7:0] TICKS     = 8'(ROUND_TICKS);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);
    localparam logic [1:0] WIN_CAP   = 2'(ROUNDS_TO_WIN);
    localparam logic [1:0] ROUND_CAP = 2'(MAX_ROUNDS);

    typedef enum logic [1:0] {IDLE, FIGHT, ROUND_END, MATCH_END} state_t;

    state_t     state_reg, state_next;
    logic       first_reg, first_next;
    logic [3:0] hold_reg, hold_next;
    logic       restart_reg, restart_next;
    logic [7:0] time_left_reg, time_left_next;
    logic [1:0] round_num_reg, round_num_next;
    logic [1:0] left_wins_reg, left_wins_next;
    logic [1:0] right_wins_reg, right_wins_next;
    logic       result_valid_reg, result_valid_next;
    logic [1:0] round_result_reg, round_result_next;
    logic       active_reg, active_next;
    logic       over_reg, over_next;
    logic [1:0] winner_reg, winner_next;

    // Health 6 and 7 are what a 0 wraps to after a hit, so they count as KO too.
    logic left_ko, right_ko;
    assign left_ko  = (left_health == 3'd0)  || (left_health >= 3'd6);
    assign right_ko = (right_health == 3'd0) || (right_health >= 3'd6);

    logic       dec_valid;
    logic [1:0] dec_code;
    always_comb begin
        dec_valid = 1'b0;
        dec_code  = 2'b00;
        if (left_ko && right_ko) begin
            dec_valid = 1'b1;
            dec_code  = 2'b11;
        end else if (left_ko) begin
            dec_valid = 1'b1;
            dec_code  = 2'b10;
        end else if (right_ko) begin
            dec_valid = 1'b1;
            dec_code  = 2'b01;
        end else if (time_left_reg == 8'd1) begin
            dec_valid = 1'b1;
            if (left_health > right_health)      dec_code = 2'b01;
            else if (right_health > left_health) dec_code = 2'b10;
            else                                 dec_code = 2'b11;
        end
    end

    always_comb begin
        state_next        = state_reg;
        first_next        = first_reg;
        hold_next         = hold_reg;
        restart_next      = 1'b0;
        time_left_next    = time_left_reg;
        round_num_next    = round_num_reg;
        left_wins_next    = left_wins_reg;
        right_wins_next   = right_wins_reg;
        result_valid_next = 1'b0;
        round_result_next = round_result_reg;
        winner_next       = winner_reg;
        case (state_reg)
            IDLE, MATCH_END: begin
                if (start) begin
                    state_next        = FIGHT;
                    first_next        = 1'b1;
                    restart_next      = 1'b1;
                    time_left_next    = TICKS;
                    round_num_next    = 2'd0;
                    left_wins_next    = 2'd0;
                    right_wins_next   = 2'd0;
                    round_result_next = 2'b00;
                    winner_next       = 2'b00;
                end
            end
            FIGHT: begin
                // The restart cycle only counts down; players are still reloading.
                if (first_reg) begin
                    first_next     = 1'b0;
                    time_left_next = time_left_reg - 8'd1;
                end else if (dec_valid) begin
                    state_next        = ROUND_END;
                    hold_next         = HOLD_LAST;
                    result_valid_next = 1'b1;
                    round_result_next = dec_code;
                    if (dec_code == 2'b01 && left_wins_reg < WIN_CAP)
                        left_wins_next = left_wins_reg + 2'd1;
                    if (dec_code == 2'b10 && right_wins_reg < WIN_CAP)
                        right_wins_next = right_wins_reg + 2'd1;
                    if (round_num_reg < ROUND_CAP)
                        round_num_next = round_num_reg + 2'd1;
                end else begin
                    time_left_next = time_left_reg - 8'd1;
                end
            end
            ROUND_END: begin
                if (hold_reg != 4'd0) begin
                    hold_next = hold_reg - 4'd1;
                end else if (left_wins_reg == WIN_CAP || right_wins_reg == WIN_CAP ||
                             round_num_reg == ROUND_CAP) begin
                    state_next = MATCH_END;
                    if (left_wins_reg > right_wins_reg)      winner_next = 2'b01;
                    else if (right_wins_reg > left_wins_reg) winner_next = 2'b10;
                    else                                     winner_next = 2'b11;
                end else begin
                    state_next     = FIGHT;
                    first_next     = 1'b1;
                    restart_next   = 1'b1;
                    time_left_next = TICKS;
                end
            end
            default: state_next = IDLE;
        endcase
        active_next = (state_next == FIGHT);
        over_next   = (state_next == MATCH_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            first_reg        <= 1'b0;
            hold_reg         <= 4'd0;
            restart_reg      <= 1'b0;
            time_left_reg    <= 8'd0;
            round_num_reg    <= 2'd0;
            left_wins_reg    <= 2'd0;
            right_wins_reg   <= 2'd0;
            result_valid_reg <= 1'b0;
            round_result_reg <= 2'b00;
            active_reg       <= 1'b0;
            over_reg         <= 1'b0;
            winner_reg       <= 2'b00;
        end else begin
            state_reg        <= state_next;
            first_reg        <= first_next;
            hold_reg         <= hold_next;
            restart_reg      <= restart_next;
            time_left_reg    <= time_left_next;
            round_num_reg    <= round_num_next;
            left_wins_reg    <= left_wins_next;
            right_wins_reg   <= right_wins_next;
            result_valid_reg <= result_valid_next;
            round_result_reg <= round_result_next;
            active_reg       <= active_next;
            over_reg         <= over_next;
            winner_reg       <= winner_next;
        end
    end

    assign round_active  = active_reg;
    assign round_restart = restart_reg;
    assign time_left     = time_left_reg;
    assign round_num     = round_num_reg;
    assign left_wins     = left_wins_reg;
    assign right_wins    = right_wins_reg;
    assign result_valid  = result_valid_reg;
    assign round_result  = round_result_reg;
    assign match_over    = over_reg;
    assign match_winner  = winner_reg;
endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: directed matches push expected round and match
// outcomes; monitors pop and compare whenever the referee announces one.
module tb_game_referee;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] left_health = 3'd3;
    logic [2:0] right_health = 3'd3;
    logic       round_active, round_restart, result_valid, match_over;
    logic [7:0] time_left;
    logic [1:0] round_num, left_wins, right_wins, round_result, match_winner;

    game_referee dut (
        .clk(clk), .rst(rst), .start(start),
        .left_health(left_health), .right_health(right_health),
        .round_active(round_active), .round_restart(round_restart),
        .time_left(time_left), .round_num(round_num),
        .left_wins(left_wins), .right_wins(right_wins),
        .result_valid(result_valid), .round_result(round_result),
        .match_over(match_over), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] res;
        logic [1:0] lw;
        logic [1:0] rw;
        logic [1:0] num;
    } round_exp_t;

    round_exp_t round_q[$];
    logic [1:0] match_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Round-decision monitor
    always @(negedge clk) begin
        if (result_valid) begin
            if (round_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                round_exp_t e;
                e = round_q.pop_front();
                $display("round decided: result=%0d L=%0d R=%0d num=%0d",
                         round_result, left_wins, right_wins, round_num);
                check("round_result", int'(round_result), int'(e.res));
                check("left_wins", int'(left_wins), int'(e.lw));
                check("right_wins", int'(right_wins), int'(e.rw));
                check("round_num", int'(round_num), int'(e.num));
                check("active_low_on_result", int'(round_active), 0);
            end
        end
    end

    // Match-end monitor
    logic over_prev = 1'b0;
    always @(negedge clk) begin
        if (match_over && !over_prev) begin
            if (match_q.size() == 0) begin
                check("unexpected_match_end", 1, 0);
            end else begin
                logic [1:0] w;
                w = match_q.pop_front();
                $display("match over: winner=%0d", match_winner);
                check("match_winner", int'(match_winner), int'(w));
                check("match_active_excl", int'(round_active | round_restart), 0);
            end
        end
        over_prev <= match_over;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_round(input logic [1:0] r, input logic [1:0] l,
                              input logic [1:0] rw, input logic [1:0] n);
        round_exp_t e;
        e.res = r; e.lw = l; e.rw = rw; e.num = n;
        round_q.push_back(e);
    endtask

    // Bounded waits return the number of ticks taken, or -1 on timeout.
    task automatic wait_result(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (result_valid) begin n = i; break; end
        end
        if (n < 0) check("wait_result_timeout", 0, 1);
    endtask

    task automatic wait_restart(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (round_restart) begin n = i; break; end
        end
        if (n < 0) check("wait_restart_timeout", 0, 1);
    endtask

    task automatic wait_match(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (match_over) begin n = i; break; end
        end
        if (n < 0) check("wait_match_timeout", 0, 1);
    endtask

    task automatic start_match();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_active", int'(round_active), 0);
        check("rst_restart", int'(round_restart), 0);
        check("rst_time_left", int'(time_left), 0);
        check("rst_round_num", int'(round_num), 0);
        check("rst_result", int'(round_result), 0);
        check("rst_over", int'(match_over), 0);
        repeat (3) tick();
        check("idle_stays", int'(round_active | round_restart), 0);

        // Match 1: start, KO win, timeout draw, timeout right win -> drawn match
        start_match();
        check("m1_restart", int'(round_restart), 1);
        check("m1_active", int'(round_active), 1);
        check("m1_time_60", int'(time_left), 60);
        tick();
        check("m1_time_59", int'(time_left), 59);
        check("m1_restart_pulse", int'(round_restart), 0);
        right_health = 3'd0;
        push_round(2'b01, 2'd1, 2'd0, 2'd1);
        tick();
        check("ko_result_next_cycle", int'(result_valid), 1);
        check("time_frozen", int'(time_left), 59);
        right_health = 3'd3;
        repeat (3) tick();
        check("hold_no_restart_yet", int'(round_restart), 0);
        check("hold_time_frozen", int'(time_left), 59);
        tick();
        check("restart_after_hold", int'(round_restart), 1);
        check("restart_time_60", int'(time_left), 60);
        push_round(2'b11, 2'd1, 2'd0, 2'd2);
        wait_result(n);
        check("draw_timeout_ticks", n, 60);
        wait_restart(n);
        check("hold_ticks_r2", n, 4);
        left_health = 3'd2;
        right_health = 3'd4;
        push_round(2'b10, 2'd1, 2'd1, 2'd3);
        match_q.push_back(2'b11);
        wait_result(n);
        check("timeout_ticks_r3", n, 60);
        wait_match(n);
        check("match_after_hold", n, 4);
        left_health = 3'd3;
        right_health = 3'd3;

        // Match 2: left wins two rounds by underflow KOs; start ignored in ROUND_END
        start_match();
        check("m2_restart", int'(round_restart), 1);
        check("m2_cleared_num", int'(round_num), 0);
        check("m2_cleared_wins", int'(left_wins) + int'(right_wins), 0);
        check("m2_cleared_result", int'(round_result), 0);
        check("m2_cleared_winner", int'(match_winner), 0);
        check("m2_over_low", int'(match_over), 0);
        right_health = 3'd7;
        push_round(2'b01, 2'd1, 2'd0, 2'd1);
        wait_result(n);
        check("no_ko_in_restart_cycle", n, 2);
        right_health = 3'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_num", int'(round_num), 1);
        wait_restart(n);
        check("start_ignored_hold", n, 3);
        right_health = 3'd6;
        push_round(2'b01, 2'd2, 2'd0, 2'd2);
        match_q.push_back(2'b01);
        wait_result(n);
        wait_match(n);
        check("m2_over_after_hold", n, 4);
        right_health = 3'd3;

        // Match 3: double KO draw, KO beats timeout, then reset during ROUND_END
        start_match();
        left_health = 3'd0;
        right_health = 3'd0;
        push_round(2'b11, 2'd0, 2'd0, 2'd1);
        wait_result(n);
        left_health = 3'd3;
        right_health = 3'd3;
        wait_restart(n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (time_left == 8'd1) begin n = i; break; end
        end
        check("reach_time_1", n, 59);
        left_health = 3'd6;
        push_round(2'b10, 2'd0, 2'd1, 2'd2);
        wait_result(n);
        check("ko_over_timeout_ticks", n, 1);
        left_health = 3'd3;
        repeat (2) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        check("mid_rst_restart", int'(round_restart), 0);
        check("mid_rst_active", int'(round_active), 0);
        check("mid_rst_time", int'(time_left), 0);
        check("mid_rst_wins", int'(right_wins), 0);
        check("mid_rst_num", int'(round_num), 0);
        check("mid_rst_result", int'(round_result), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (4) tick();
        check("post_rst_idle", int'(round_active | round_restart | match_over), 0);

        check("round_q_drained", round_q.size(), 0);
        check("match_q_drained", match_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
